// File: rtl/mc_common_pkg.sv
// Shared memory-channel request/response types and the arbiter policy enum.
package mc_common_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
  } mem_resp_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/tag_fifo.sv
// Small synchronous FIFO holding requester indices of in-flight L2 transactions.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Push is refused while full even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_rr_arbiter_ot.sv
// N-to-1 L2 request arbiter (round-robin or fixed priority) with an outstanding
// limit and in-order response routing back to the issuing requester.
module l2_rr_arbiter_ot
  import mc_common_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEPTH      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  mem_req_t               req [N],
  output logic [N-1:0]           req_ready,
  output mem_resp_t              rsp [N],
  output mem_req_t               l2_req,
  input  logic                   l2_req_ready,
  input  mem_resp_t              l2_resp,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_orphan
);

  localparam int        IW   = $clog2(N);
  localparam arb_mode_e MODE = (FIXED_PRIO != 0) ? ARB_FIXED : ARB_RR;

  logic [IW-1:0] ptr, grant, head;
  logic          full, empty, accept, pop;

  // Scan from ptr (RR) or from 0 (fixed); idle grant parks on ptr.
  always_comb begin : grant_sel
    int  k;
    logic found;
    k     = 0;
    found = 1'b0;
    grant = ptr;
    for (int i = 0; i < N; i++) begin
      if (MODE == ARB_FIXED) begin
        k = i;
      end else begin
        k = int'(ptr) + i;
        if (k >= N) k = k - N;
      end
      if (!found && req[k].valid) begin
        grant = IW'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    l2_req       = req[grant];
    l2_req.valid = req[grant].valid && !full;
  end

  // rst_n keeps every req_ready low while reset is held.
  assign accept = l2_req.valid && l2_req_ready && rst_n;
  assign pop    = l2_resp.valid && !empty;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ready[i] = accept && (grant == IW'(i));
      rsp[i]       = (pop && head == IW'(i)) ? l2_resp : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (MODE == ARB_RR && accept) begin
      ptr <= (grant == IW'(N-1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan <= 1'b0;
    end else if (l2_resp.valid && empty) begin
      err_orphan <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (grant),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_l2_rr_arbiter_ot.sv
// Bench for l2_rr_arbiter_ot: an RR and a fixed-priority instance share stimulus;
// a queue-based model is compared every cycle, plus directed literal checks.
module tb_l2_rr_arbiter_ot;
  import mc_common_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic      clk = 1'b0;
  logic      rst_n;
  mem_req_t  req [N];
  logic      l2_req_ready;
  mem_resp_t l2_resp;

  logic [N-1:0]  rr_ready, fx_ready;
  mem_resp_t     rr_rsp [N];
  mem_resp_t     fx_rsp [N];
  mem_req_t      rr_l2, fx_l2;
  logic [OW-1:0] rr_out, fx_out;
  logic          rr_err, fx_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  l2_rr_arbiter_ot #(.N(N), .DEPTH(DEPTH), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ready(rr_ready), .rsp(rr_rsp),
    .l2_req(rr_l2), .l2_req_ready(l2_req_ready), .l2_resp(l2_resp),
    .outstanding(rr_out), .err_orphan(rr_err));

  l2_rr_arbiter_ot #(.N(N), .DEPTH(DEPTH), .FIXED_PRIO(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ready(fx_ready), .rsp(fx_rsp),
    .l2_req(fx_l2), .l2_req_ready(l2_req_ready), .l2_resp(l2_resp),
    .outstanding(fx_out), .err_orphan(fx_err));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: tags in a queue, ptr as an integer, sticky orphan bit.
  int ptr_m [2];
  int q0[$];
  int q1[$];
  bit orph_m [2];

  function automatic int qsz(int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int pick(int m);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m == 0) ? (ptr_m[m] + i) % N : i;
      if (req[k].valid) return k;
    end
    return ptr_m[m];
  endfunction

  task automatic check_inst(input int m, input mem_req_t a_l2, input logic [N-1:0] a_rdy,
                            input mem_resp_t a_rsp [N], input logic [OW-1:0] a_out,
                            input logic a_err);
    int g, qs, hd;
    mem_req_t e_l2;
    logic [N-1:0] e_rdy;
    mem_resp_t e_rsp;
    bit acc;
    string tag;
    tag = (m == 0) ? "rr" : "fx";
    if (!rst_n) begin
      ptr_m[m] = 0;
      orph_m[m] = 1'b0;
      if (m == 0) q0.delete(); else q1.delete();
    end
    qs = qsz(m);
    hd = (qs > 0) ? qfront(m) : -1;
    g  = pick(m);
    e_l2 = req[g];
    if (qs == DEPTH) e_l2.valid = 1'b0;
    acc   = e_l2.valid && l2_req_ready && rst_n;
    e_rdy = acc ? (N'(1) << g) : '0;
    chk({tag, "_l2_req"}, a_l2, e_l2);
    chk({tag, "_req_ready"}, a_rdy, e_rdy);
    chk({tag, "_outstanding"}, a_out, qs);
    chk({tag, "_err_orphan"}, a_err, orph_m[m]);
    for (int k = 0; k < N; k++) begin
      e_rsp = (rst_n && l2_resp.valid && qs > 0 && hd == k) ? l2_resp : '0;
      chk($sformatf("%s_rsp%0d", tag, k), a_rsp[k], e_rsp);
    end
    if (rst_n) begin
      if (l2_resp.valid) begin
        if (qs > 0) begin
          if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end else begin
          orph_m[m] = 1'b1;
        end
      end
      if (acc) begin
        if (m == 0) q0.push_back(g); else q1.push_back(g);
        if (m == 0) ptr_m[m] = (g + 1) % N;
      end
    end
  endtask

  always @(negedge clk) begin
    check_inst(0, rr_l2, rr_ready, rr_rsp, rr_out, rr_err);
    check_inst(1, fx_l2, fx_ready, fx_rsp, fx_out, fx_err);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      req[k].valid = v[k];
      req[k].we    = k[0];
      req[k].addr  = 32'h100 + 32'(k * 4);
      req[k].wdata = 32'(k * 'h11);
    end
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    l2_resp.valid = v;
    l2_resp.rdata = v ? d : '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    set_req('0);
    while (rr_out != 0 && n < 2 * DEPTH) begin
      resp(1'b1, 32'hD000 + 32'(n));
      nxt();
      n++;
    end
    resp(1'b0, '0);
    chk("drain_empty", rr_out, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    l2_req_ready = 1'b1;
    resp(1'b0, '0);
    set_req(4'b0001);
    @(negedge clk);
    chk("rst_outstanding", rr_out, 0);
    chk("rst_err", rr_err, 0);
    chk("rst_ready_gated", rr_ready, 4'b0000);
    chk("rst_l2_valid", rr_l2.valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req('0);
    nxt();

    // All four valid, one response per cycle from the 2nd cycle.
    set_req(4'hF);
    for (int i = 0; i < 8; i++) begin
      if (i >= 1) resp(1'b1, 32'hA0 + 32'(i));
      @(negedge clk);
      chk($sformatf("t1_rr_grant%0d", i), rr_ready, N'(1) << (i % 4));
      chk($sformatf("t1_fx_grant%0d", i), fx_ready, 4'b0001);
      nxt();
    end
    set_req('0);
    resp(1'b1, 32'hA8);
    @(negedge clk);
    chk("t1_rr_last_rsp3", rr_rsp[3], {1'b1, 32'hA8});
    chk("t1_fx_last_rsp0", fx_rsp[0], {1'b1, 32'hA8});
    nxt();
    resp(1'b0, '0);

    // Stalled requester keeps its slot; ptr moves past it on accept.
    set_req(4'b0100);
    l2_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", rr_l2.valid, 1);
      chk("t2_stall_ready", rr_ready, 4'b0000);
      nxt();
    end
    l2_req_ready = 1'b1;
    @(negedge clk);
    chk("t2_accept", rr_ready, 4'b0100);
    nxt();
    set_req(4'b1001);
    @(negedge clk);
    chk("t2_ptr3", rr_ready, 4'b1000);
    chk("t2_fx_low", fx_ready, 4'b0001);
    nxt();
    set_req('0);
    resp(1'b1, 32'hB0);
    @(negedge clk);
    chk("t2_rsp2", rr_rsp[2], {1'b1, 32'hB0});
    nxt();
    resp(1'b1, 32'hB1);
    @(negedge clk);
    chk("t2_rsp3", rr_rsp[3], {1'b1, 32'hB1});
    chk("t2_fx_rsp0", fx_rsp[0], {1'b1, 32'hB1});
    nxt();
    resp(1'b0, '0);

    // req[1] and req[3] contend.
    set_req(4'b1010);
    for (int i = 0; i < 4; i++) begin
      if (i >= 1) resp(1'b1, 32'hC0 + 32'(i));
      @(negedge clk);
      chk($sformatf("t3_fx%0d", i), fx_ready, 4'b0010);
      chk($sformatf("t3_rr%0d", i), rr_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      nxt();
    end
    set_req(4'b1000);
    @(negedge clk);
    chk("t3_fx_drop", fx_ready, 4'b1000);
    nxt();
    drain();

    // Fill to DEPTH, then one response frees exactly one slot.
    set_req(4'b0010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4_fill%0d", i), rr_ready, 4'b0010);
      nxt();
    end
    @(negedge clk);
    chk("t4_full_out", rr_out, 4);
    chk("t4_full_valid", rr_l2.valid, 0);
    chk("t4_full_ready", rr_ready, 4'b0000);
    nxt();
    resp(1'b1, 32'h55);
    @(negedge clk);
    chk("t4_rsp1", rr_rsp[1], {1'b1, 32'h55});
    chk("t4_rsp0_zero", rr_rsp[0], 0);
    chk("t4_no_bypass", rr_l2.valid, 0);
    nxt();
    resp(1'b0, '0);
    @(negedge clk);
    chk("t4_out3", rr_out, 3);
    chk("t4_reaccept", rr_ready, 4'b0010);
    nxt();
    drain();

    // Grants 2,0,3 then responses A,B,C.
    set_req(4'b0100); nxt();
    set_req(4'b0001); nxt();
    set_req(4'b1000); nxt();
    set_req('0);
    resp(1'b1, 32'hAAAA);
    @(negedge clk);
    chk("t5_A_rsp2", rr_rsp[2], {1'b1, 32'hAAAA});
    chk("t5_A_others", {rr_rsp[0], rr_rsp[1], rr_rsp[3]}, 0);
    nxt();
    resp(1'b1, 32'hBBBB);
    @(negedge clk);
    chk("t5_B_rsp0", rr_rsp[0], {1'b1, 32'hBBBB});
    chk("t5_B_others", {rr_rsp[1], rr_rsp[2], rr_rsp[3]}, 0);
    nxt();
    resp(1'b1, 32'hCCCC);
    @(negedge clk);
    chk("t5_C_rsp3", rr_rsp[3], {1'b1, 32'hCCCC});
    chk("t5_C_others", {rr_rsp[0], rr_rsp[1], rr_rsp[2]}, 0);
    nxt();
    resp(1'b0, '0);
    @(negedge clk);
    chk("t5_out0", rr_out, 0);
    nxt();

    // Orphan response, sticky flag, cleared by reset.
    resp(1'b1, 32'hDEAD);
    @(negedge clk);
    chk("t6_orphan_rsp", {rr_rsp[0], rr_rsp[1], rr_rsp[2], rr_rsp[3]}, 0);
    nxt();
    resp(1'b0, '0);
    @(negedge clk);
    chk("t6_err_set", rr_err, 1);
    chk("t6_fx_err_set", fx_err, 1);
    nxt();
    @(negedge clk);
    chk("t6_err_sticky", rr_err, 1);
    nxt();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", rr_err, 0);
    chk("t6_out_clr", rr_out, 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // Reset mid-flight discards tags; a late response is an orphan.
    set_req(4'b0001); nxt(); nxt();
    set_req('0);
    @(negedge clk);
    chk("t7_inflight", rr_out, 2);
    nxt();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_out", rr_out, 0);
    nxt();
    rst_n = 1'b1;
    nxt();
    resp(1'b1, 32'h77);
    @(negedge clk);
    chk("t7_late_rsp0", rr_rsp[0], 0);
    chk("t7_err_pre", rr_err, 0);
    nxt();
    resp(1'b0, '0);
    @(negedge clk);
    chk("t7_err_post", rr_err, 1);
    nxt();
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
